// File: rtl/uart_fifo_bridge.sv
// Byte bridge between a host FIFO interface and a simple UART core: 16-deep TX/RX FIFOs,
// TX start/handshake FSM and RX capture. Define UART_FIFO_OVR_EN to build the sticky RX overrun flag.
module uart_fifo_bridge #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            tx_data,
   input  logic                  tx_wr,
   output logic                  tx_full,
   output logic [DEPTH_LOG2:0]   tx_count,
   output logic [7:0]            rx_data,
   input  logic                  rx_rd,
   output logic                  rx_empty,
   output logic [DEPTH_LOG2:0]   rx_count,
   output logic [7:0]            u_din,
   output logic                  u_start,
   input  logic                  u_busy,
   input  logic [7:0]            u_dout,
   input  logic                  u_has_byte,
   output logic                  u_clr_hb,
   output logic                  rx_ovr,
   input  logic                  ovr_clr
);

   localparam int unsigned AW    = DEPTH_LOG2;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_HI = 2'd1,
      WAIT_LO = 2'd2
   } tx_state_t;

   logic [7:0]    tx_mem [DEPTH];
   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] tx_wptr;
   logic [AW-1:0] tx_rptr;
   logic [AW-1:0] rx_wptr;
   logic [AW-1:0] rx_rptr;

   tx_state_t     state;
   logic [1:0]    tmo;
   logic          tx_en;

   logic          tx_push;
   logic          tx_pop;
   logic          rx_full;
   logic          rx_cap;
   logic          rx_push;
   logic          rx_pop;
   logic          rx_drop;

   // FIFO status decodes straight from the registered occupancy counters
   assign tx_full  = (tx_count == CW'(DEPTH));
   assign rx_full  = (rx_count == CW'(DEPTH));
   assign rx_empty = (rx_count == CW'(0));
   assign rx_data  = rx_mem[rx_rptr];

   assign tx_push = tx_wr && !tx_full;
   assign tx_pop  = (state == IDLE) && tx_en && (tx_count != CW'(0)) && !u_busy;

   // A byte arriving on a full FIFO is still taken when the host pops in the same cycle
   assign rx_cap  = u_has_byte && !u_clr_hb;
   assign rx_pop  = rx_rd && !rx_empty;
   assign rx_push = rx_cap && (!rx_full || rx_rd);
   assign rx_drop = rx_cap && rx_full && !rx_rd;

   always_ff @(posedge clk) begin
      if (tx_push) begin
         tx_mem[tx_wptr] <= tx_data;
      end
      if (rx_push) begin
         rx_mem[rx_wptr] <= u_dout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_count <= '0;
      end else begin
         if (tx_push) begin
            tx_wptr <= tx_wptr + AW'(1);
         end
         if (tx_pop) begin
            tx_rptr <= tx_rptr + AW'(1);
         end
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + CW'(1);
            2'b01:   tx_count <= tx_count - CW'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_count <= '0;
         u_clr_hb <= 1'b0;
      end else begin
         u_clr_hb <= rx_cap;
         if (rx_push) begin
            rx_wptr <= rx_wptr + AW'(1);
         end
         if (rx_pop) begin
            rx_rptr <= rx_rptr + AW'(1);
         end
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CW'(1);
            2'b01:   rx_count <= rx_count - CW'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

   // TX handshake: start a byte, wait for busy to rise (3-cycle timeout), then for it to fall.
   // tx_en holds off the first start for one edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         tmo     <= 2'd0;
         tx_en   <= 1'b0;
         u_start <= 1'b0;
         u_din   <= 8'h00;
      end else begin
         tx_en   <= 1'b1;
         u_start <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_pop) begin
                  u_din   <= tx_mem[tx_rptr];
                  u_start <= 1'b1;
                  tmo     <= 2'd0;
                  state   <= WAIT_HI;
               end
            end
            WAIT_HI: begin
               if (u_busy) begin
                  state <= WAIT_LO;
               end else if (tmo == 2'd2) begin
                  state <= IDLE;
               end else begin
                  tmo <= tmo + 2'd1;
               end
            end
            WAIT_LO: begin
               if (!u_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef UART_FIFO_OVR_EN
   // Sticky overrun; a drop in the same cycle as a clear keeps the flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_ovr <= 1'b0;
      end else if (rx_drop) begin
         rx_ovr <= 1'b1;
      end else if (ovr_clr) begin
         rx_ovr <= 1'b0;
      end
   end
`else
   logic unused_ovr;
   assign rx_ovr     = 1'b0;
   assign unused_ovr = ovr_clr ^ rx_drop;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Randomized self-checking bench for uart_fifo_bridge against a queue-based reference model.
module tb_uart_fifo_bridge;

   localparam int unsigned DL2   = 4;
   localparam int          DEPTH = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic [7:0]   tx_data;
   logic         tx_wr;
   logic         tx_full;
   logic [DL2:0] tx_count;
   logic [7:0]   rx_data;
   logic         rx_rd;
   logic         rx_empty;
   logic [DL2:0] rx_count;
   logic [7:0]   u_din;
   logic         u_start;
   logic         u_busy;
   logic [7:0]   u_dout;
   logic         u_has_byte;
   logic         u_clr_hb;
   logic         rx_ovr;
   logic         ovr_clr;

   uart_fifo_bridge #(.DEPTH_LOG2(DL2)) dut (
      .clk(clk), .rst_n(rst_n),
      .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full), .tx_count(tx_count),
      .rx_data(rx_data), .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_count(rx_count),
      .u_din(u_din), .u_start(u_start), .u_busy(u_busy), .u_dout(u_dout),
      .u_has_byte(u_has_byte), .u_clr_hb(u_clr_hb), .rx_ovr(rx_ovr), .ovr_clr(ovr_clr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [7:0] txq[$];
   logic [7:0] rxq[$];
   bit         exp_clr;
   bit         exp_ovr;
   logic [7:0] last_din;
   int         cyc, last_start, last_gap, starts, clr_seen, stall;
   // UART behaviour
   int         pend, hold_left, cur_hold, hold_cfg;
   bit         force_busy, rx_auto;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: apply current inputs at the edge, then update the model and compare
   task automatic tick();
      int         pre;
      bit         acc, pop, cap, drop;
      logic [7:0] hd;
      @(posedge clk);
      #1;
      cyc++;
      pre = txq.size();
      acc = tx_wr && (pre < DEPTH);
      if (u_start) begin
         starts++;
         last_gap = cyc - last_start;
         chk("start_gap", 32'(last_gap >= 3), 32'(1));
         last_start = cyc;
         if (pre == 0) begin
            chk("start_when_empty", 32'(1), 32'(0));
         end else begin
            hd = txq.pop_front();
            chk("u_din", 32'(u_din), 32'(hd));
            last_din = hd;
         end
      end else begin
         chk("u_din_hold", 32'(u_din), 32'(last_din));
      end
      if (acc) txq.push_back(tx_data);
      chk("tx_count", 32'(tx_count), 32'(txq.size()));
      chk("tx_full", 32'(tx_full), 32'(txq.size() == DEPTH));
      if (!u_start && txq.size() > 0 && !u_busy && !force_busy) stall++;
      else stall = 0;
      if (stall > 8) begin
         chk("tx_stall", 32'(stall), 32'(0));
         stall = 0;
      end

      pre  = rxq.size();
      pop  = rx_rd && (pre > 0);
      cap  = u_has_byte && !exp_clr;
      drop = cap && (pre == DEPTH) && !pop;
      if (pop) void'(rxq.pop_front());
      if (cap && !drop) rxq.push_back(u_dout);
      exp_clr = cap;
`ifdef UART_FIFO_OVR_EN
      if (drop) exp_ovr = 1'b1;
      else if (ovr_clr) exp_ovr = 1'b0;
`endif
      if (u_clr_hb) clr_seen++;
      chk("u_clr_hb", 32'(u_clr_hb), 32'(exp_clr));
      chk("rx_count", 32'(rx_count), 32'(rxq.size()));
      chk("rx_empty", 32'(rx_empty), 32'(rxq.size() == 0));
      if (rxq.size() > 0) chk("rx_data", 32'(rx_data), 32'(rxq[0]));
      chk("rx_ovr", 32'(rx_ovr), 32'(exp_ovr));

      if (force_busy) begin
         u_busy = 1'b1;
      end else begin
         if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) u_busy = 1'b0;
         end
         if (pend > 0) begin
            pend--;
            if (pend == 0 && cur_hold > 0) begin
               u_busy    = 1'b1;
               hold_left = cur_hold;
            end
         end
         if (u_start) begin
            pend     = 1;
            cur_hold = (hold_cfg >= 0) ? hold_cfg : int'($urandom_range(0, 6));
         end
      end
      if (u_clr_hb) begin
         u_has_byte = 1'b0;
      end else if (rx_auto && !u_has_byte && $urandom_range(0, 2) == 0) begin
         u_has_byte = 1'b1;
         u_dout     = 8'($urandom);
      end
      tx_wr   = 1'b0;
      rx_rd   = 1'b0;
      ovr_clr = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_u_start", 32'(u_start), 32'(0));
      chk("rst_u_clr_hb", 32'(u_clr_hb), 32'(0));
      chk("rst_u_din", 32'(u_din), 32'(0));
      chk("rst_tx_count", 32'(tx_count), 32'(0));
      chk("rst_tx_full", 32'(tx_full), 32'(0));
      chk("rst_rx_count", 32'(rx_count), 32'(0));
      chk("rst_rx_empty", 32'(rx_empty), 32'(1));
      chk("rst_rx_ovr", 32'(rx_ovr), 32'(0));
      txq.delete();
      rxq.delete();
      exp_clr = 1'b0; exp_ovr = 1'b0; last_din = 8'h00;
      last_start = cyc - 10; stall = 0;
      u_busy = 1'b0; pend = 0; hold_left = 0; force_busy = 1'b0;
      u_has_byte = 1'b0; tx_wr = 1'b0; rx_rd = 1'b0; ovr_clr = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int s0, c0;
      bit got;
      logic [7:0] burst [3];
      tx_data = 8'h00; tx_wr = 1'b0; rx_rd = 1'b0; u_busy = 1'b0;
      u_dout = 8'h00; u_has_byte = 1'b0; ovr_clr = 1'b0;
      cyc = 0; starts = 0; clr_seen = 0; last_gap = 0;
      hold_cfg = 20; cur_hold = 0; rx_auto = 1'b0;
      do_reset();

      // Burst of three bytes with a slow UART
      burst[0] = 8'h41; burst[1] = 8'h42; burst[2] = 8'h43;
      s0 = starts;
      for (int i = 0; i < 3; i++) begin
         tx_data = burst[i]; tx_wr = 1'b1; tick();
      end
      repeat (100) tick();
      chk("burst_starts", 32'(starts - s0), 32'(3));
      chk("burst_drained", 32'(tx_count), 32'(0));

      // TX full with the UART held busy
      force_busy = 1'b1; u_busy = 1'b1;
      tick();
      for (int i = 0; i < 17; i++) begin
         tx_data = 8'(8'h80 + i); tx_wr = 1'b1; tick();
         if (i == 15) chk("full_after_16", 32'(tx_full), 32'(1));
      end
      chk("full_count", 32'(tx_count), 32'(16));
      force_busy = 1'b0; u_busy = 1'b0; pend = 0; hold_left = 0; hold_cfg = 3;
      for (int k = 0; k < 400 && tx_count != 0; k++) tick();
      chk("full_drained", 32'(tx_count), 32'(0));

      // Single received byte
      c0 = clr_seen;
      u_dout = 8'h5A; u_has_byte = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin tick(); got = u_clr_hb; end
      chk("rx_clr_seen", 32'(got), 32'(1));
      repeat (3) tick();
      chk("rx_one_pulse", 32'(clr_seen - c0), 32'(1));
      chk("rx_byte", 32'(rx_data), 32'(8'h5A));
      chk("rx_one", 32'(rx_count), 32'(1));
      rx_rd = 1'b1; tick();
      chk("rx_empty_after_rd", 32'(rx_empty), 32'(1));

      // RX overrun: 17 bytes without reads
      c0 = clr_seen;
      for (int i = 0; i < 17; i++) begin
         u_dout = 8'(i * 7 + 1); u_has_byte = 1'b1;
         got = 1'b0;
         for (int k = 0; k < 8 && !got; k++) begin tick(); got = u_clr_hb; end
         chk("ovr_clr_wait", 32'(got), 32'(1));
      end
      tick();
      chk("ovr_count", 32'(rx_count), 32'(16));
      chk("ovr_pulses", 32'(clr_seen - c0), 32'(17));
`ifdef UART_FIFO_OVR_EN
      chk("ovr_flag", 32'(rx_ovr), 32'(1));
`else
      chk("ovr_flag", 32'(rx_ovr), 32'(0));
`endif
      ovr_clr = 1'b1; tick();
      chk("ovr_cleared", 32'(rx_ovr), 32'(0));
      for (int k = 0; k < 40 && !rx_empty; k++) begin rx_rd = 1'b1; tick(); end
      chk("rx_drained", 32'(rx_empty), 32'(1));

      // Busy never rises: timeout then next byte
      hold_cfg = 0; s0 = starts;
      tx_data = 8'hC1; tx_wr = 1'b1; tick();
      tx_data = 8'hC2; tx_wr = 1'b1; tick();
      for (int k = 0; k < 40 && (starts - s0) < 2; k++) tick();
      chk("timeout_starts", 32'(starts - s0), 32'(2));
      chk("timeout_gap", 32'(last_gap >= 4 && last_gap <= 5), 32'(1));
      repeat (10) tick();

      // Reset while waiting for busy to fall, five bytes still queued
      hold_cfg = 20;
      for (int i = 0; i < 6; i++) begin
         tx_data = 8'(8'hD0 + i); tx_wr = 1'b1; tick();
      end
      for (int k = 0; k < 20 && !u_busy; k++) tick();
      tick();
      chk("pre_reset_count", 32'(tx_count), 32'(5));
      do_reset();
      s0 = starts;
      repeat (20) tick();
      chk("no_start_after_reset", 32'(starts - s0), 32'(0));
      tx_data = 8'h99; tx_wr = 1'b1; tick();
      repeat (10) tick();
      chk("start_after_wr", 32'(starts - s0), 32'(1));
      repeat (30) tick();

      // Random traffic on both paths
      rx_auto = 1'b1; hold_cfg = -1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            tx_wr = 1'b1; tx_data = 8'($urandom);
         end
         rx_rd   = (i < 750) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) == 0);
         ovr_clr = ($urandom_range(0, 19) == 0);
         tick();
      end
      rx_auto = 1'b0;
      for (int k = 0; k < 600 && tx_count != 0; k++) tick();
      chk("random_tx_drained", 32'(tx_count), 32'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
